bsc_ptw_arbiter: RTL and testbench
==================================

BSC_PTW_ARBITER -- requirements
Module: ptw_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, PTW response watchdog limit in cycles (range 2..65535).
REQ-002 SHALL have port clk_i  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush_i  in  1  CSR flush; aborts or discards the walk in flight.
REQ-005 SHALL have port itlb_req_valid_i  in  1  iTLB miss request.
REQ-006 SHALL have port itlb_req_vpn_i  in  27  iTLB miss VPN.
REQ-007 SHALL have port itlb_req_prv_i  in  2  iTLB privilege level.
REQ-008 SHALL have port itlb_req_ready_o  out  1  iTLB request accepted this cycle.
REQ-009 SHALL have port itlb_resp_valid_o  out  1  one-cycle response pulse to iTLB.
REQ-010 SHALL have port dtlb_req_valid_i  in  1  dTLB miss request.
REQ-011 SHALL have port dtlb_req_vpn_i  in  27  dTLB miss VPN.
REQ-012 SHALL have port dtlb_req_prv_i  in  2  dTLB privilege level.
REQ-013 SHALL have port dtlb_req_store_i  in  1  dTLB miss caused by store.
REQ-014 SHALL have port dtlb_req_ready_o  out  1  dTLB request accepted this cycle.
REQ-015 SHALL have port dtlb_resp_valid_o  out  1  one-cycle response pulse to dTLB.
REQ-016 SHALL have port ptw_req_valid_o  out  1  request to PTW.
REQ-017 SHALL have port ptw_req_vpn_o  out  27  registered VPN of owner.
REQ-018 SHALL have port ptw_req_prv_o  out  2  registered privilege of owner.
REQ-019 SHALL have port ptw_req_store_o  out  1  registered store flag (0 for iTLB).
REQ-020 SHALL have port ptw_req_fetch_o  out  1  1 when owner is iTLB.
REQ-021 SHALL have port ptw_req_ready_i  in  1  PTW accepts request.
REQ-022 SHALL have port ptw_resp_valid_i  in  1  PTW walk completed.
REQ-023 SHALL have port ptw_resp_pte_i  in  38  {error, level[1:0], perm[7:0] = d,a,g,u,x,w,r,v, ppn[26:0]}.
REQ-024 SHALL have port tlb_resp_pte_o  out  38  registered response, same packing, shared by both TLBs.
REQ-025 SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-026 SHALL have port pmu_conflict_o  out  1  pulse when both TLBs request in IDLE.

Function
REQ-027 SHALL implement FSM IDLE, ISSUE, WAIT, DRAIN; exactly one walk outstanding.
REQ-028 IDLE: if any valid, SHALL grant one (combinational ready to winner only), register its fields and owner, go ISSUE; ready is 0 in all other states.
REQ-029 Both valid SHALL grant by round-robin pointer (reset: dTLB first); after each grant pointer points to the other TLB; single requester always wins.
REQ-030 ISSUE: ptw_req_valid_o=1 with stable fields; on ptw_req_ready_i go WAIT.
REQ-031 WAIT: on ptw_resp_valid_i, SHALL register ptw_resp_pte_i and pulse owner's resp_valid_o next cycle (latency 1), then IDLE; other TLB's resp_valid_o stays 0.
REQ-032 flush_i in ISSUE without ptw_req_ready_i: drop request, IDLE, no response; with ptw_req_ready_i same cycle: DRAIN.
REQ-033 flush_i in WAIT (including same cycle as ptw_resp_valid_i): DRAIN, response discarded; DRAIN waits for ptw_resp_valid_i, discards it, goes IDLE.
REQ-034 ptw_resp_valid_i in IDLE or ISSUE SHALL be ignored; flush_i in IDLE has no effect.

Reset
REQ-035 rstn_i low SHALL immediately force IDLE, all outputs 0, pointer to dTLB, watchdog counter 0, including mid-walk.
REQ-036 No response pulse SHALL be generated for a walk killed by reset.

Configuration
REQ-037 With PTW_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT/DRAIN; at TIMEOUT_CYCLES cycles without response, WAIT delivers error response (error=1, rest 0) via REQ-031 timing, DRAIN goes IDLE.
REQ-038 Without PTW_ARB_TIMEOUT_EN, no counter SHALL exist and WAIT/DRAIN wait indefinitely.

Verification
REQ-039 iTLB vpn=0x1234 alone, PTW ready at once, resp ppn=0x5A5A after 3 cycles -> fetch=1, itlb_resp_valid_o one pulse, tlb_resp_pte_o ppn=0x5A5A.
REQ-040 Both valid after reset -> dTLB granted, pmu_conflict_o=1; next IDLE iTLB granted.
REQ-041 dTLB store vpn=0x7FF, flush_i in WAIT, resp 2 cycles later -> no resp pulse, busy_o low after response.
REQ-042 flush_i in ISSUE with ptw_req_ready_i=0 -> IDLE next cycle, no PTW handshake.
REQ-043 PTW_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> owner error pulse 9 cycles after WAIT entry, IDLE.
REQ-044 rstn_i low during WAIT, late response after release -> ignored, all outputs 0.

Source files
------------

// File: rtl/bsc_ptw_arbiter.sv
// Arbitrates iTLB/dTLB misses onto a single page-table-walker port, one walk outstanding.
// Optional response watchdog is built when the macro PTW_ARB_TIMEOUT_EN is defined.
module bsc_ptw_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        flush_i,
    input  logic        itlb_req_valid_i,
    input  logic [26:0] itlb_req_vpn_i,
    input  logic [1:0]  itlb_req_prv_i,
    output logic        itlb_req_ready_o,
    output logic        itlb_resp_valid_o,
    input  logic        dtlb_req_valid_i,
    input  logic [26:0] dtlb_req_vpn_i,
    input  logic [1:0]  dtlb_req_prv_i,
    input  logic        dtlb_req_store_i,
    output logic        dtlb_req_ready_o,
    output logic        dtlb_resp_valid_o,
    output logic        ptw_req_valid_o,
    output logic [26:0] ptw_req_vpn_o,
    output logic [1:0]  ptw_req_prv_o,
    output logic        ptw_req_store_o,
    output logic        ptw_req_fetch_o,
    input  logic        ptw_req_ready_i,
    input  logic        ptw_resp_valid_i,
    input  logic [37:0] ptw_resp_pte_i,
    output logic [37:0] tlb_resp_pte_o,
    output logic        busy_o,
    output logic        pmu_conflict_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [37:0] ERR_PTE = {1'b1, 37'd0};

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..65535");
    end

    logic [1:0]  state_q, state_d;
    logic        rr_q, rr_d;        // 1: iTLB wins the next conflict
    logic [26:0] vpn_q, vpn_d;
    logic [1:0]  prv_q, prv_d;
    logic        store_q, store_d;
    logic        fetch_q, fetch_d;
    logic [37:0] pte_q, pte_d;
    logic        iresp_q, iresp_d;
    logic        dresp_q, dresp_d;
    logic        timeout;
    logic        in_idle;
    logic        grant_i;
    logic        grant_d;

    assign in_idle = (state_q == IDLE);
    // Readies are combinational, so they are held low while reset is asserted.
    assign grant_i = rstn_i && in_idle && itlb_req_valid_i && (!dtlb_req_valid_i || rr_q);
    assign grant_d = rstn_i && in_idle && dtlb_req_valid_i && (!itlb_req_valid_i || !rr_q);

`ifdef PTW_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    logic [15:0] wdog_q, wdog_d;

    // Restarts on every state change, so DRAIN gets its own full window.
    always_comb begin
        wdog_d = '0;
        if (((state_q == WAIT) || (state_q == DRAIN)) && (state_d == state_q)) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    assign timeout = (wdog_q == TIMEOUT_LIM);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        vpn_d   = vpn_q;
        prv_d   = prv_q;
        store_d = store_q;
        fetch_d = fetch_q;
        pte_d   = pte_q;
        iresp_d = 1'b0;
        dresp_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    vpn_d   = itlb_req_vpn_i;
                    prv_d   = itlb_req_prv_i;
                    store_d = 1'b0;
                    fetch_d = 1'b1;
                    rr_d    = 1'b0;
                    state_d = ISSUE;
                end else if (grant_d) begin
                    vpn_d   = dtlb_req_vpn_i;
                    prv_d   = dtlb_req_prv_i;
                    store_d = dtlb_req_store_i;
                    fetch_d = 1'b0;
                    rr_d    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (flush_i) begin
                    state_d = ptw_req_ready_i ? DRAIN : IDLE;
                end else if (ptw_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_d = DRAIN;
                end else if (ptw_resp_valid_i || timeout) begin
                    pte_d   = ptw_resp_valid_i ? ptw_resp_pte_i : ERR_PTE;
                    iresp_d = fetch_q;
                    dresp_d = !fetch_q;
                    state_d = IDLE;
                end
            end
            default: begin
                if (ptw_resp_valid_i || timeout) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            vpn_q   <= '0;
            prv_q   <= '0;
            store_q <= 1'b0;
            fetch_q <= 1'b0;
            pte_q   <= '0;
            iresp_q <= 1'b0;
            dresp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            vpn_q   <= vpn_d;
            prv_q   <= prv_d;
            store_q <= store_d;
            fetch_q <= fetch_d;
            pte_q   <= pte_d;
            iresp_q <= iresp_d;
            dresp_q <= dresp_d;
        end
    end

    assign itlb_req_ready_o  = grant_i;
    assign dtlb_req_ready_o  = grant_d;
    assign itlb_resp_valid_o = iresp_q;
    assign dtlb_resp_valid_o = dresp_q;
    assign ptw_req_valid_o   = (state_q == ISSUE);
    assign ptw_req_vpn_o     = vpn_q;
    assign ptw_req_prv_o     = prv_q;
    assign ptw_req_store_o   = store_q;
    assign ptw_req_fetch_o   = fetch_q;
    assign tlb_resp_pte_o    = pte_q;
    assign busy_o            = !in_idle;
    assign pmu_conflict_o    = rstn_i && in_idle && itlb_req_valid_i && dtlb_req_valid_i;

endmodule

// File: tb/tb_bsc_ptw_arbiter.sv
// Self-checking bench for bsc_ptw_arbiter: directed scenarios plus randomized transaction schedules.
module tb_bsc_ptw_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        flush_i;
    logic        itlb_req_valid_i;
    logic [26:0] itlb_req_vpn_i;
    logic [1:0]  itlb_req_prv_i;
    logic        itlb_req_ready_o;
    logic        itlb_resp_valid_o;
    logic        dtlb_req_valid_i;
    logic [26:0] dtlb_req_vpn_i;
    logic [1:0]  dtlb_req_prv_i;
    logic        dtlb_req_store_i;
    logic        dtlb_req_ready_o;
    logic        dtlb_resp_valid_o;
    logic        ptw_req_valid_o;
    logic [26:0] ptw_req_vpn_o;
    logic [1:0]  ptw_req_prv_o;
    logic        ptw_req_store_o;
    logic        ptw_req_fetch_o;
    logic        ptw_req_ready_i;
    logic        ptw_resp_valid_i;
    logic [37:0] ptw_resp_pte_i;
    logic [37:0] tlb_resp_pte_o;
    logic        busy_o;
    logic        pmu_conflict_o;

    int checks = 0;
    int errors = 0;

    bsc_ptw_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
        .itlb_req_valid_i(itlb_req_valid_i), .itlb_req_vpn_i(itlb_req_vpn_i),
        .itlb_req_prv_i(itlb_req_prv_i), .itlb_req_ready_o(itlb_req_ready_o),
        .itlb_resp_valid_o(itlb_resp_valid_o),
        .dtlb_req_valid_i(dtlb_req_valid_i), .dtlb_req_vpn_i(dtlb_req_vpn_i),
        .dtlb_req_prv_i(dtlb_req_prv_i), .dtlb_req_store_i(dtlb_req_store_i),
        .dtlb_req_ready_o(dtlb_req_ready_o), .dtlb_resp_valid_o(dtlb_resp_valid_o),
        .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_vpn_o(ptw_req_vpn_o),
        .ptw_req_prv_o(ptw_req_prv_o), .ptw_req_store_o(ptw_req_store_o),
        .ptw_req_fetch_o(ptw_req_fetch_o), .ptw_req_ready_i(ptw_req_ready_i),
        .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_pte_i(ptw_resp_pte_i),
        .tlb_resp_pte_o(tlb_resp_pte_o), .busy_o(busy_o), .pmu_conflict_o(pmu_conflict_o)
    );

    always #5 clk_i = ~clk_i;

    logic [75:0] outs;
    assign outs = {itlb_req_ready_o, itlb_resp_valid_o, dtlb_req_ready_o, dtlb_resp_valid_o,
                   ptw_req_valid_o, ptw_req_vpn_o, ptw_req_prv_o, ptw_req_store_o,
                   ptw_req_fetch_o, tlb_resp_pte_o, busy_o, pmu_conflict_o};

    // One cycle: inputs are driven 1 ns after the rising edge, outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        flush_i = 0; itlb_req_valid_i = 0; itlb_req_vpn_i = '0; itlb_req_prv_i = '0;
        dtlb_req_valid_i = 0; dtlb_req_vpn_i = '0; dtlb_req_prv_i = '0; dtlb_req_store_i = 0;
        ptw_req_ready_i = 0; ptw_resp_valid_i = 0; ptw_resp_pte_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn_i = 0;
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn_i = 0;
        #3;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h exp 0", outs); end
        itlb_req_valid_i = 1; dtlb_req_valid_i = 1;
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_req_held: got %h exp 0", outs); end
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1;
    endtask

    task automatic test_itlb_basic();
        tick();
        itlb_req_valid_i = 1; itlb_req_vpn_i = 27'h1234; itlb_req_prv_i = 2'd1;
        #1;
        checks++;
        if ({itlb_req_ready_o, dtlb_req_ready_o, pmu_conflict_o} !== 3'b100) begin
            errors++; $display("FAIL itlb_grant: got %b exp 100", {itlb_req_ready_o, dtlb_req_ready_o, pmu_conflict_o});
        end
        tick();
        itlb_req_valid_i = 0; ptw_req_ready_i = 1;
        #1;
        checks++;
        if ({ptw_req_valid_o, ptw_req_fetch_o, ptw_req_store_o, ptw_req_vpn_o, ptw_req_prv_o, busy_o}
            !== {1'b1, 1'b1, 1'b0, 27'h1234, 2'd1, 1'b1}) begin
            errors++; $display("FAIL itlb_issue: got v%b f%b s%b vpn %h prv %0d", ptw_req_valid_o,
                               ptw_req_fetch_o, ptw_req_store_o, ptw_req_vpn_o, ptw_req_prv_o);
        end
        tick();
        ptw_req_ready_i = 0;
        #1;
        checks++;
        if ({ptw_req_valid_o, busy_o} !== 2'b01) begin
            errors++; $display("FAIL itlb_wait: got %b exp 01", {ptw_req_valid_o, busy_o});
        end
        repeat (2) tick();
        tick();
        ptw_resp_valid_i = 1; ptw_resp_pte_i = {1'b0, 2'd2, 8'hCF, 27'h5A5A};
        #1;
        checks++;
        if (itlb_resp_valid_o !== 1'b0) begin errors++; $display("FAIL itlb_early_pulse: got 1 exp 0"); end
        tick();
        ptw_resp_valid_i = 0;
        #1;
        checks++;
        if ({itlb_resp_valid_o, dtlb_resp_valid_o, busy_o} !== 3'b100 ||
            tlb_resp_pte_o !== {1'b0, 2'd2, 8'hCF, 27'h5A5A}) begin
            errors++; $display("FAIL itlb_resp: got %b pte %h exp 100 pte %h",
                               {itlb_resp_valid_o, dtlb_resp_valid_o, busy_o}, tlb_resp_pte_o,
                               {1'b0, 2'd2, 8'hCF, 27'h5A5A});
        end
        tick();
        checks++;
        if (itlb_resp_valid_o !== 1'b0) begin errors++; $display("FAIL itlb_pulse_width: got 1 exp 0"); end
    endtask

    task automatic test_conflict();
        do_reset();
        for (int unsigned r = 0; r < 2; r++) begin
            tick();
            itlb_req_valid_i = 1; itlb_req_vpn_i = 27'h111; dtlb_req_valid_i = 1; dtlb_req_vpn_i = 27'h222;
            #1;
            checks++;
            if ({itlb_req_ready_o, dtlb_req_ready_o, pmu_conflict_o} !== ((r == 0) ? 3'b011 : 3'b101)) begin
                errors++; $display("FAIL conflict_grant%0d: got %b exp %b", r,
                                   {itlb_req_ready_o, dtlb_req_ready_o, pmu_conflict_o}, (r == 0) ? 3'b011 : 3'b101);
            end
            tick();
            itlb_req_valid_i = 0; dtlb_req_valid_i = 0; ptw_req_ready_i = 1;
            #1;
            checks++;
            if ({ptw_req_fetch_o, ptw_req_vpn_o} !== ((r == 0) ? {1'b0, 27'h222} : {1'b1, 27'h111})) begin
                errors++; $display("FAIL conflict_owner%0d: got f%b vpn %h", r, ptw_req_fetch_o, ptw_req_vpn_o);
            end
            tick(); ptw_req_ready_i = 0;
            tick(); ptw_resp_valid_i = 1;
            tick(); ptw_resp_valid_i = 0;
            #1;
            checks++;
            if ({itlb_resp_valid_o, dtlb_resp_valid_o} !== ((r == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL conflict_resp%0d: got %b", r, {itlb_resp_valid_o, dtlb_resp_valid_o});
            end
        end
    endtask

    task automatic test_flush_wait();
        tick();
        dtlb_req_valid_i = 1; dtlb_req_vpn_i = 27'h7FF; dtlb_req_store_i = 1;
        tick();
        dtlb_req_valid_i = 0; dtlb_req_store_i = 0; ptw_req_ready_i = 1;
        #1;
        checks++;
        if ({ptw_req_valid_o, ptw_req_store_o, ptw_req_fetch_o, ptw_req_vpn_o} !== {3'b110, 27'h7FF}) begin
            errors++; $display("FAIL flushw_issue: got v%b s%b f%b vpn %h", ptw_req_valid_o,
                               ptw_req_store_o, ptw_req_fetch_o, ptw_req_vpn_o);
        end
        tick(); ptw_req_ready_i = 0; flush_i = 1;
        tick(); flush_i = 0;
        tick(); ptw_resp_valid_i = 1; ptw_resp_pte_i = 38'h12345;
        #1;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL flushw_drain_busy: got 0 exp 1"); end
        tick(); ptw_resp_valid_i = 0;
        #1;
        checks++;
        if ({busy_o, itlb_resp_valid_o, dtlb_resp_valid_o} !== 3'b000) begin
            errors++; $display("FAIL flushw_done: got %b exp 000", {busy_o, itlb_resp_valid_o, dtlb_resp_valid_o});
        end
        tick();
        checks++;
        if ({itlb_resp_valid_o, dtlb_resp_valid_o} !== 2'b00) begin
            errors++; $display("FAIL flushw_nopulse: got %b exp 00", {itlb_resp_valid_o, dtlb_resp_valid_o});
        end
    endtask

    task automatic test_flush_issue();
        tick(); itlb_req_valid_i = 1; itlb_req_vpn_i = 27'h4321;
        tick(); itlb_req_valid_i = 0; flush_i = 1;
        #1;
        checks++;
        if (ptw_req_valid_o !== 1'b1) begin errors++; $display("FAIL flushi_issue: got 0 exp 1"); end
        tick(); flush_i = 0;
        #1;
        checks++;
        if ({busy_o, ptw_req_valid_o} !== 2'b00) begin
            errors++; $display("FAIL flushi_idle: got %b exp 00", {busy_o, ptw_req_valid_o});
        end
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({busy_o, ptw_req_valid_o, itlb_resp_valid_o, dtlb_resp_valid_o} !== 4'b0000) begin
                errors++; $display("FAIL flushi_quiet%0d: got %b exp 0000", i,
                                   {busy_o, ptw_req_valid_o, itlb_resp_valid_o, dtlb_resp_valid_o});
            end
        end
    endtask

    task automatic test_timeout();
        tick(); dtlb_req_valid_i = 1; dtlb_req_vpn_i = 27'h55;
        tick(); dtlb_req_valid_i = 0; ptw_req_ready_i = 1;
        tick(); ptw_req_ready_i = 0;
`ifdef PTW_ARB_TIMEOUT_EN
        // The cycle just entered is WAIT index 0; the error pulse is due at index 9.
        for (int unsigned i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if ({dtlb_resp_valid_o, itlb_resp_valid_o} !== ((i == 9) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL timeout_pulse idx %0d: got %b", i, {dtlb_resp_valid_o, itlb_resp_valid_o});
            end
        end
        checks++;
        if ({busy_o, tlb_resp_pte_o} !== {1'b0, 1'b1, 37'd0}) begin
            errors++; $display("FAIL timeout_err: got busy %b pte %h", busy_o, tlb_resp_pte_o);
        end
`else
        for (int unsigned i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if ({busy_o, dtlb_resp_valid_o, itlb_resp_valid_o} !== 3'b100) begin
                errors++; $display("FAIL no_timeout idx %0d: got %b exp 100", i, {busy_o, dtlb_resp_valid_o, itlb_resp_valid_o});
            end
        end
        ptw_resp_valid_i = 1;
        tick(); ptw_resp_valid_i = 0;
        #1;
        checks++;
        if ({busy_o, dtlb_resp_valid_o} !== 2'b01) begin
            errors++; $display("FAIL late_resp: got %b exp 01", {busy_o, dtlb_resp_valid_o});
        end
`endif
    endtask

    task automatic test_reset_midwalk();
        tick(); itlb_req_valid_i = 1; itlb_req_vpn_i = 27'h6789;
        tick(); itlb_req_valid_i = 0; ptw_req_ready_i = 1;
        tick(); ptw_req_ready_i = 0;
        #2 rstn_i = 0;
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL midreset_outs: got %h exp 0", outs); end
        tick();
        rstn_i = 1; ptw_resp_valid_i = 1; ptw_resp_pte_i = 38'h3ABCDEF01;
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL midreset_release: got %h exp 0", outs); end
        tick(); ptw_resp_valid_i = 0; ptw_resp_pte_i = '0;
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL midreset_late_resp: got %h exp 0", outs); end
    endtask

    typedef struct {
        bit iv, dv, dst, prdy, rv, fl;
        logic [26:0] ivpn, dvpn;
        logic [1:0]  iprv, dprv;
        logic [37:0] pte;
        bit e_ir, e_dr, e_conf, e_pv, e_busy, e_ip, e_dp, chk_f;
        logic [26:0] e_vpn;
        logic [1:0]  e_prv;
        bit e_st, e_fe;
        logic [37:0] e_pte;
    } cyc_t;

    function automatic cyc_t blank();
        cyc_t c;
        c = '{default: '0};
        return c;
    endfunction

    task automatic test_random();
        cyc_t sched[$];
        cyc_t c, f;
        bit rr_i;   // model of arbitration priority: 1 when iTLB should win a conflict
        bit win_i;
        logic [63:0] r;
        int unsigned scn, w, w2;
        do_reset();
        rr_i = 0;
        for (int unsigned t = 0; t < 80; t++) begin
            c = blank();
            do begin c.iv = $urandom_range(0, 1); c.dv = $urandom_range(0, 1); end while (!(c.iv || c.dv));
            c.ivpn = 27'($urandom); c.dvpn = 27'($urandom);
            c.iprv = 2'($urandom); c.dprv = 2'($urandom); c.dst = $urandom_range(0, 1);
            win_i = c.iv && (!c.dv || rr_i);
            rr_i = !win_i;
            c.e_ir = win_i; c.e_dr = !win_i; c.e_conf = c.iv && c.dv;
            sched.push_back(c);
            f = blank();
            f.e_pv = 1; f.e_busy = 1; f.chk_f = 1; f.e_fe = win_i;
            f.e_vpn = win_i ? c.ivpn : c.dvpn; f.e_prv = win_i ? c.iprv : c.dprv;
            f.e_st = win_i ? 1'b0 : c.dst;
            for (int unsigned k = $urandom_range(0, 2); k > 0; k--) begin
                c = f; c.rv = $urandom_range(0, 1); sched.push_back(c);
            end
            scn = $urandom_range(0, 3);
            w = $urandom_range(0, 4);
            w2 = $urandom_range(0, 4);
            c = f; c.prdy = (scn != 1); c.fl = (scn == 1) || (scn == 2);
            sched.push_back(c);
            if (scn == 1) begin
                c = blank(); c.rv = $urandom_range(0, 1); c.fl = $urandom_range(0, 1); sched.push_back(c);
            end else begin
                for (int unsigned i = 0; i < w; i++) begin c = blank(); c.e_busy = 1; sched.push_back(c); end
                if (scn == 3) begin
                    c = blank(); c.e_busy = 1; c.fl = 1; sched.push_back(c);
                    for (int unsigned i = 0; i < w2; i++) begin c = blank(); c.e_busy = 1; sched.push_back(c); end
                end
                r = {$urandom, $urandom};
                c = blank(); c.e_busy = 1; c.rv = 1; c.pte = r[37:0]; sched.push_back(c);
            end
            f = blank();
            if (scn == 0) begin f.e_ip = win_i; f.e_dp = !win_i; f.e_pte = c.pte; end
            sched.push_back(f);
        end
        foreach (sched[n]) begin
            c = sched[n];
            tick();
            itlb_req_valid_i = c.iv; itlb_req_vpn_i = c.ivpn; itlb_req_prv_i = c.iprv;
            dtlb_req_valid_i = c.dv; dtlb_req_vpn_i = c.dvpn; dtlb_req_prv_i = c.dprv;
            dtlb_req_store_i = c.dst; ptw_req_ready_i = c.prdy; ptw_resp_valid_i = c.rv;
            ptw_resp_pte_i = c.pte; flush_i = c.fl;
            #1;
            checks++;
            if ({itlb_req_ready_o, dtlb_req_ready_o, pmu_conflict_o} !== {c.e_ir, c.e_dr, c.e_conf}) begin
                errors++; $display("FAIL rnd_grant cyc %0d: got %b exp %b", n,
                                   {itlb_req_ready_o, dtlb_req_ready_o, pmu_conflict_o}, {c.e_ir, c.e_dr, c.e_conf});
            end
            checks++;
            if ({ptw_req_valid_o, busy_o, itlb_resp_valid_o, dtlb_resp_valid_o} !== {c.e_pv, c.e_busy, c.e_ip, c.e_dp}) begin
                errors++; $display("FAIL rnd_ctrl cyc %0d: got %b exp %b", n,
                                   {ptw_req_valid_o, busy_o, itlb_resp_valid_o, dtlb_resp_valid_o},
                                   {c.e_pv, c.e_busy, c.e_ip, c.e_dp});
            end
            if (c.chk_f) begin
                checks++;
                if ({ptw_req_vpn_o, ptw_req_prv_o, ptw_req_store_o, ptw_req_fetch_o} !== {c.e_vpn, c.e_prv, c.e_st, c.e_fe}) begin
                    errors++; $display("FAIL rnd_fields cyc %0d: got %h exp %h", n,
                                       {ptw_req_vpn_o, ptw_req_prv_o, ptw_req_store_o, ptw_req_fetch_o},
                                       {c.e_vpn, c.e_prv, c.e_st, c.e_fe});
                end
            end
            if (c.e_ip || c.e_dp) begin
                checks++;
                if (tlb_resp_pte_o !== c.e_pte) begin
                    errors++; $display("FAIL rnd_pte cyc %0d: got %h exp %h", n, tlb_resp_pte_o, c.e_pte);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_itlb_basic();
        test_conflict();
        test_flush_wait();
        test_flush_issue();
        test_timeout();
        test_reset_midwalk();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
